// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared up/down counter
// to NUM_REQ requesters, one timed job at a time, with a RUN-phase watchdog.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   req/req_dir         per-requester request level and count direction (1 = up)
//   load_val            packed per-requester load values, WIDTH bits each
//   cnt_zero            zero flag returned by the shared counter
//   cnt_load_n/mode/in  counter control pins (cnt_load_n low loads cnt_in)
//   gnt/done/err/busy   one-hot grant, completion and watchdog-abort pulses, busy
module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_RUN = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_dir,
  input  logic [NUM_REQ*WIDTH-1:0]   load_val,
  input  logic                       cnt_zero,
  output logic                       cnt_load_n,
  output logic                       cnt_mode,
  output logic [WIDTH-1:0]           cnt_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Watchdog width depends only on MAX_RUN, never on the data path width.
  localparam int WW = (MAX_RUN > 1) ? $clog2(MAX_RUN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        g_q, g_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [WW-1:0]        wdog_q, wdog_d;

  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 cnt_load_n_q, cnt_load_n_d;
  logic                 cnt_mode_q, cnt_mode_d;
  logic [WIDTH-1:0]     cnt_in_q, cnt_in_d;

  // Round-robin pick: first requesting index at or above the pointer, wrapping.
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Pointer value used on every return to IDLE: one past the served requester.
  logic [IW-1:0] ptr_nxt;
  always_comb begin
    ptr_nxt = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
  end

  logic go_idle;

  // Outputs are computed for the state being entered and registered alongside
  // the state, so every output is a flop and matches the state it belongs to.
  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    ptr_d        = ptr_q;
    wdog_d       = wdog_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = '0;
    busy_d       = busy_q;
    cnt_load_n_d = cnt_load_n_q;
    cnt_mode_d   = cnt_mode_q;
    cnt_in_d     = cnt_in_q;
    go_idle      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d      = S_LOAD;
          g_d          = pick_idx;
          gnt_d        = NUM_REQ'(1) << pick_idx;
          busy_d       = 1'b1;
          cnt_load_n_d = 1'b0;
          cnt_in_d     = load_val[int'(pick_idx)*WIDTH +: WIDTH];
          cnt_mode_d   = req_dir[pick_idx];
          wdog_d       = '0;
        end
      end

      S_LOAD: begin
        // Release the counter; mode and preload stay as captured.
        state_d      = S_RUN;
        cnt_load_n_d = 1'b1;
        wdog_d       = WW'(1);
      end

      S_RUN: begin
        if (!req[g_q]) begin
          // Requester withdrew: silent drop, no pulse.
          go_idle = 1'b1;
        end else if (cnt_zero) begin
          state_d      = S_DONE;
          done_d       = gnt_q;
          cnt_load_n_d = 1'b0;
          cnt_in_d     = '0;
        end else if (wdog_q == WW'(MAX_RUN)) begin
          state_d      = S_ABORT;
          err_d        = gnt_q;
          cnt_load_n_d = 1'b0;
          cnt_in_d     = '0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end

      S_DONE, S_ABORT: begin
        go_idle = 1'b1;
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Common exit to IDLE: park the counter, drop grant and advance pointer.
    if (go_idle) begin
      state_d      = S_IDLE;
      gnt_d        = '0;
      busy_d       = 1'b0;
      cnt_load_n_d = 1'b0;
      cnt_in_d     = '0;
      ptr_d        = ptr_nxt;
      wdog_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      g_q          <= '0;
      ptr_q        <= '0;
      wdog_q       <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      cnt_load_n_q <= 1'b0;
      cnt_mode_q   <= 1'b0;
      cnt_in_q     <= '0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      ptr_q        <= ptr_d;
      wdog_q       <= wdog_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cnt_load_n_q <= cnt_load_n_d;
      cnt_mode_q   <= cnt_mode_d;
      cnt_in_q     <= cnt_in_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign cnt_load_n = cnt_load_n_q;
  assign cnt_mode   = cnt_mode_q;
  assign cnt_in     = cnt_in_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: counter model, scoreboard of expected done/err
// pulses (index, kind, RUN length) checked by an independent monitor.
module tb_counter_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int MAX_RUN = 10;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_dir;
  logic [NUM_REQ*WIDTH-1:0] load_val;
  logic                     cnt_zero;
  logic                     cnt_load_n;
  logic                     cnt_mode;
  logic [WIDTH-1:0]         cnt_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;
  logic                     busy;

  counter_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dir(req_dir), .load_val(load_val),
    .cnt_zero(cnt_zero), .cnt_load_n(cnt_load_n), .cnt_mode(cnt_mode),
    .cnt_in(cnt_in), .gnt(gnt), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared counter model: loads while cnt_load_n low, up mode wraps 60 -> 0.
  logic [WIDTH-1:0] cnt_m = '0;
  logic             stall = 1'b0;
  always @(posedge clk) begin
    if (!cnt_load_n)   cnt_m <= cnt_in;
    else if (stall)    cnt_m <= cnt_m;
    else if (cnt_mode) cnt_m <= (cnt_m == 8'd60) ? 8'd0 : cnt_m + 8'd1;
    else               cnt_m <= cnt_m - 8'd1;
  end
  assign cnt_zero = (cnt_m == '0);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    int idx;
    bit is_err;
    int run_len;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops one expectation per done/err pulse.
  int cyc = 0;
  int start_cyc = 0;
  logic [NUM_REQ-1:0] prev_gnt = '0;
  initial begin
    exp_t e;
    logic [NUM_REQ-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (gnt != '0 && prev_gnt == '0) start_cyc = cyc;
      prev_gnt = gnt;
      if ((done | err) != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%b err=%b with nothing expected", done, err);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.idx;
          check("pulse_done", 32'(done), e.is_err ? 32'd0 : 32'(oh));
          check("pulse_err",  32'(err),  e.is_err ? 32'(oh) : 32'd0);
          check("pulse_gnt",  32'(gnt),  32'(oh));
          check("run_len",    32'(cyc - start_cyc - 1), 32'(e.run_len));
        end
      end
    end
  end

  task automatic push_exp(input int idx, input bit is_err, input int run_len);
    exp_t e;
    e.idx = idx; e.is_err = is_err; e.run_len = run_len;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (gnt != '0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_gnt");
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((done | err) != '0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_pulse");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},   32'(gnt),        32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_ldn"},   32'(cnt_load_n), 32'd0);
    check({tag, "_cin"},   32'(cnt_in),     32'd0);
    check({tag, "_cmode"}, 32'(cnt_mode),   32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One job from a single requester; expectation supplied by the caller.
  task automatic do_job(input int idx, input bit dir, input int v, input bit stl,
                        input bit exp_err, input int exp_len);
    int n; bit ok;
    load_val[idx*WIDTH +: WIDTH] = WIDTH'(v);
    req_dir[idx] = dir;
    stall = stl;
    push_exp(idx, exp_err, exp_len);
    req[idx] = 1'b1;
    wait_gnt(n, ok);
    if (ok) wait_pulse(ok);
    req[idx] = 1'b0;
    stall = 1'b0;
    @(negedge clk);
  endtask

  // All requesters ask with V = 0; the first grant reveals the pointer.
  task automatic ptr_probe(input int exp_idx, input string name);
    int n; bit ok;
    load_val = '0;
    req_dir  = '0;
    push_exp(exp_idx, 1'b0, 1);
    req = '1;
    wait_gnt(n, ok);
    check(name, 32'(gnt), 32'(4'b0001 << exp_idx));
    if (ok) wait_pulse(ok);
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    int n; bit ok;
    rst_n = 1'b0; req = '0; req_dir = '0; load_val = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single down job, V = 5: LOAD shows the preload, zero in RUN cycle 6.
    load_val[0 +: WIDTH] = 8'd5;
    req_dir[0] = 1'b0;
    push_exp(0, 1'b0, 6);
    req = 4'b0001;
    wait_gnt(n, ok);
    check("load_gnt",  32'(gnt),        32'd1);
    check("load_ldn",  32'(cnt_load_n), 32'd0);
    check("load_cin",  32'(cnt_in),     32'd5);
    check("load_mode", 32'(cnt_mode),   32'd0);
    check("load_busy", 32'(busy),       32'd1);
    @(negedge clk);
    check("run_ldn",   32'(cnt_load_n), 32'd1);
    check("run_cin",   32'(cnt_in),     32'd5);
    wait_pulse(ok);
    req = '0;
    @(negedge clk);
    check("after_gnt",  32'(gnt),  32'd0);
    check("after_busy", 32'(busy), 32'd0);

    // Round robin with all four held, V = 2 down: order 0,1,2,3,0.
    do_reset();
    load_val = {4{8'd2}};
    req_dir  = '0;
    for (int i = 0; i < 5; i++) push_exp(i % 4, 1'b0, 3);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(n, ok);
      if (!ok) break;
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      if (i > 0) check("rr_gap", 32'(n), 32'd2);
      wait_pulse(ok);
      if (i == 4) req = '0;
    end
    @(negedge clk);

    // Up mode and zero-length jobs; V = 9 down hits zero on the watchdog's
    // last cycle, where done takes priority over abort.
    do_job(2, 1'b1, 58, 1'b0, 1'b0, 4);
    do_job(1, 1'b1, 0,  1'b0, 1'b0, 1);
    do_job(0, 1'b0, 0,  1'b0, 1'b0, 1);
    do_job(3, 1'b0, 9,  1'b0, 1'b0, 10);
    do_job(0, 1'b0, 10, 1'b0, 1'b1, 10);

    // Watchdog abort with a stalled counter; pointer moves on to 2.
    do_job(1, 1'b0, 50, 1'b1, 1'b1, 10);
    ptr_probe(2, "ptr_after_abort");

    // Silent drop of requester 3 in RUN cycle 3; pointer wraps to 0.
    load_val[3*WIDTH +: WIDTH] = 8'd50;
    req_dir[3] = 1'b0;
    req = 4'b1000;
    wait_gnt(n, ok);
    repeat (3) @(negedge clk);
    check("drop_run_gnt", 32'(gnt),        32'd8);
    check("drop_run_ldn", 32'(cnt_load_n), 32'd1);
    req = '0;
    @(negedge clk);
    check("drop_gnt",  32'(gnt),        32'd0);
    check("drop_busy", 32'(busy),       32'd0);
    check("drop_ldn",  32'(cnt_load_n), 32'd0);
    check("drop_cin",  32'(cnt_in),     32'd0);
    repeat (3) @(negedge clk);
    ptr_probe(0, "ptr_after_drop");

    // Reset in the middle of RUN: everything back to reset values.
    load_val[2*WIDTH +: WIDTH] = 8'd50;
    req_dir[2] = 1'b1;
    req = 4'b0100;
    wait_gnt(n, ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_rst");
    req = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one up/down counter datapath between NUM_REQ requesters.
- Each requester asks for one timed count: a load value plus a direction. The block runs one job at a time and serves requesters in round-robin order.
- The block drives the counter's load, mode and input pins, watches its zero output, and returns a done or error pulse to the granted requester.
- It sits between the requesters and the counter. While this block owns the counter, it is the only thing that drives the counter's control pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the counter data path.
- MAX_RUN, 255, longest allowed RUN phase in cycles before the watchdog aborts the job.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  request level, one bit per requester. Held high until done or err.
- req_dir  in  NUM_REQ  direction per requester: 1 = up, 0 = down.
- load_val  in  NUM_REQ*WIDTH  packed load values. Requester i uses bits [i*WIDTH +: WIDTH].
- cnt_zero  in  1  zero flag from the counter.
- cnt_load_n  out  1  drives the counter's rst_n pin. Low loads cnt_in.
- cnt_mode  out  1  drives the counter's mode pin: 1 = up, 0 = down.
- cnt_in  out  WIDTH  drives the counter's preload input.
- gnt  out  NUM_REQ  one-hot grant.
- done  out  NUM_REQ  one-cycle pulse when a job completes.
- err  out  NUM_REQ  one-cycle pulse when the watchdog aborts a job.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset (when rst_n is low at a clock edge):
- state = IDLE; gnt, done and err = 0; busy = 0.
- cnt_load_n = 0, cnt_in = 0, cnt_mode = 0.
- Round-robin pointer = 0; watchdog counter = 0.
- Reset mid-job aborts the job with no done or err pulse.

State machine: IDLE, LOAD, RUN, DONE, ABORT. All outputs are registered.

IDLE:
- Counter is parked: cnt_load_n = 0, cnt_in = 0.
- If any req bit is high, pick the first set bit starting at the pointer and wrapping upward. Capture its index g, go to LOAD, and set gnt[g].

LOAD (exactly 1 cycle):
- cnt_load_n = 0, cnt_in = load_val[g], cnt_mode = req_dir[g].
- Go to RUN.

RUN:
- cnt_load_n = 1; cnt_mode and cnt_in are held at their LOAD values.
- The watchdog counter increments every cycle, starting from 1 on the first RUN cycle.
- Exits, in priority order:
  1. req[g] low: abort silently (no done, no err) and go to IDLE.
  2. cnt_zero high: go to DONE.
  3. Watchdog = MAX_RUN: go to ABORT.

DONE (1 cycle):
- done[g] = 1, cnt_load_n = 0, cnt_in = 0.
- Go to IDLE.

ABORT (1 cycle):
- err[g] = 1, with the same counter park as DONE.
- Go to IDLE.

gnt and pointer:
- gnt[g] is high from LOAD through DONE/ABORT inclusive, and low in IDLE.
- On leaving to IDLE, the pointer becomes (g+1) mod NUM_REQ. This applies to completion, abort and silent drop alike.

RUN length, for load value V:
- Down mode: the counter reads V in the first RUN cycle, so cnt_zero is seen in RUN cycle V+1.
- Up mode: the counter wraps 60 to 0, so for V ≤ 60 cnt_zero is seen in RUN cycle 62−V.
- Up mode with V > 60: the counter counts up and wraps at 2^WIDTH, reaching 0 at RUN cycle 2^WIDTH−V+1.
- V = 0 in either mode: cnt_zero is seen in RUN cycle 1.

Other rules:
- Minimum spacing between back-to-back jobs is 1 IDLE cycle.
- A requester must not see done and a new gnt in the same cycle.
- req changes on non-granted bits during a job have no effect.
- The watchdog compare is WIDTH-independent; size the counter to clog2(MAX_RUN+1).

Test Plan:
- Reset then req = 0001, load_val[0] = 5, down → LOAD 1 cycle with cnt_in = 5; cnt_zero seen in RUN cycle 6; done[0] pulses on the next cycle; gnt = 0000 and busy = 0 afterwards.
- req = 1111 held, all load_val = 2 down → grants in order 0,1,2,3,0; each job takes LOAD + 3 RUN + DONE; one IDLE cycle between jobs.
- req[2] with up mode, V = 58 → cnt_zero in RUN cycle 4, done[2]. V = 0 (either mode) → DONE after 1 RUN cycle.
- MAX_RUN = 10, req[1] with V = 50 down, counter model stalled → err[1] pulse after RUN cycle 10, no done, pointer = 2.
- req[3] dropped in RUN cycle 3 → IDLE next cycle, no done or err, pointer = 0. Separately: rst_n low mid-RUN → all outputs return to their reset values on the next edge.
